nmi_arb: RTL
============

// Module: nmi_arb
// PURPOSE
//  Round-robin arbiter sharing one NMI (valid/ready native memory) slave between NUM_MST masters.
//  Sits between CPU/DMA/debug masters and the shared bus or crossbar port.
//  Grants one master per transaction and holds the grant until the slave returns ready.
//  Routes the slave response back to the granted master.
// PARAMETERS
//  NUM_MST      4    number of masters, 2..8; index 0 has first priority out of reset
//  TIMEOUT_CYC  255  watchdog limit in cycles; used only with NMI_ARB_TIMEOUT_EN
// PORTS
//  clk_i        in   1          clock; the only clock in the block
//  rst_i        in   1          reset, synchronous, active-high
//  mst_valid_i  in   NUM_MST    per-master request valid
//  mst_addr_i   in   NUM_MST*32 per-master address; master i at [32*i +: 32]
//  mst_wdata_i  in   NUM_MST*32 per-master write data
//  mst_wstrb_i  in   NUM_MST*4  per-master byte strobes; 0 = read
//  mst_rdata_o  out  32         read data, broadcast to all masters
//  mst_ready_o  out  NUM_MST    per-master completion pulse
//  slv_valid_o  out  1          request to the shared slave
//  slv_addr_o   out  32         address to the slave
//  slv_wdata_o  out  32         write data to the slave
//  slv_wstrb_o  out  4          byte strobes to the slave
//  slv_rdata_i  in   32         slave read data
//  slv_ready_i  in   1          slave completion pulse
//  grant_o      out  NUM_MST    one-hot current grant; 0 when IDLE
//  busy_o       out  1          1 while in BUSY
// BEHAVIOUR
//  - FSM states: IDLE and BUSY.
//  - Registered: state, grant (one-hot), last_grant index.
//  - Reset: state=IDLE, grant=0, last_grant=NUM_MST-1, so master 0 wins first.
//  - Reset outputs: slv_valid_o=0, slv_addr/wdata/wstrb_o=0, mst_ready_o=0, mst_rdata_o=0, busy_o=0.
//  - Reset mid-transaction aborts silently; no ready is issued to any master.
//  - IDLE: if any mst_valid_i is set, pick the first requester searching from last_grant+1 upward, wrapping modulo NUM_MST.
//  - IDLE: register that pick into grant and go to BUSY. Arbitration latency is 1 cycle.
//  - IDLE: with no requests, stay in IDLE.
//  - BUSY: slv_valid_o=1. slv_addr/wdata/wstrb_o pass through combinationally from the granted master.
//  - Outside BUSY, slv_addr/wdata/wstrb_o=0.
//  - BUSY with slv_ready_i=1:
//      - mst_ready_o[grant]=1 that same cycle (combinational). All other mst_ready_o bits stay 0.
//      - mst_rdata_o=slv_rdata_i that same cycle.
//      - last_grant <= granted index; grant <= 0; go to IDLE.
//  - Minimum spacing: one IDLE cycle between back-to-back transactions.
//  - Fairness: a master that just completed has lowest priority next round.
//  - Grant is held while BUSY even if the granted master drops valid (protocol violation). The slave still sees the request.
//  - Requests from other masters during BUSY wait. They are never dropped or reordered.
//  - slv_ready_i in IDLE is ignored.
//  - mst_rdata_o=0 whenever no ready is being issued.
//  - Single master requesting continuously: re-granted every 2nd cycle minimum.
// CONFIGURATION
//  NMI_ARB_TIMEOUT_EN defined:
//    - 8-bit-or-wider counter clears on entering BUSY and increments each BUSY cycle without slv_ready_i.
//    - When it reaches TIMEOUT_CYC: mst_ready_o[grant]=1 for one cycle, mst_rdata_o=32'hDEAD_BEEF, return to IDLE.
//    - The same cycle also sets sticky output timeout_o (1 bit); only rst_i clears it.
//    - If slv_ready_i arrives in that same cycle, the slave response wins and timeout_o is not set.
//  NMI_ARB_TIMEOUT_EN undefined:
//    - No counter and no timeout_o port. BUSY waits indefinitely for slv_ready_i.
// TESTING
//  1 Reset, then m0 and m2 raise valid together -> grant_o=4'b0001 next cycle. m0 served first, then m2.
//  2 All 4 masters hold valid, slave answers ready 1 cycle after valid -> grants cycle 0,1,2,3,0.
//    No master is ready twice before the others are served.
//  3 m1 reads addr 32'h0000_1000, slave returns rdata=32'hCAFE_0001 after 3 cycles
//    -> mst_ready_o=4'b0010 and mst_rdata_o=32'hCAFE_0001 in that cycle only.
//  4 m3 writes wstrb=4'b0011, wdata=32'h1234_5678 -> slv_wstrb_o/slv_wdata_o match while BUSY.
//    The slave sees exactly one request.
//  5 rst_i asserted while BUSY on m2 -> next cycle slv_valid_o=0, grant_o=0, no mst_ready_o pulse.
//  6 (NMI_ARB_TIMEOUT_EN, TIMEOUT_CYC=16) slave never ready
//    -> after 16 BUSY cycles, mst_ready_o pulses with rdata 32'hDEAD_BEEF and timeout_o=1 until reset.

Source files
------------

// File: rtl/nmi_arb.sv
// nmi_arb: round-robin arbiter sharing one NMI (valid/ready) slave between
// NUM_MST masters. One grant per transaction, held until the slave is ready.
//
// Parameters:
//   NUM_MST      number of masters (2..8); master 0 wins first after reset
//   TIMEOUT_CYC  watchdog limit in BUSY cycles (NMI_ARB_TIMEOUT_EN only)
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   mst_valid_i            per-master request valid
//   mst_addr_i/wdata_i     per-master 32-bit fields, master i at [32*i +: 32]
//   mst_wstrb_i            per-master byte strobes at [4*i +: 4], 0 = read
//   mst_rdata_o            read data broadcast, 0 unless a ready is issued
//   mst_ready_o            per-master completion pulse
//   slv_valid_o/addr_o/wdata_o/wstrb_o  request to the shared slave
//   slv_rdata_i/ready_i    slave response
//   grant_o                one-hot current grant, 0 when idle
//   busy_o                 high while a transaction is outstanding
//   timeout_o              sticky watchdog flag (NMI_ARB_TIMEOUT_EN only)
// Build option: define NMI_ARB_TIMEOUT_EN to add the BUSY watchdog.
module nmi_arb #(
    parameter int NUM_MST     = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_MST-1:0]    mst_valid_i,
    input  logic [NUM_MST*32-1:0] mst_addr_i,
    input  logic [NUM_MST*32-1:0] mst_wdata_i,
    input  logic [NUM_MST*4-1:0]  mst_wstrb_i,
    output logic [31:0]           mst_rdata_o,
    output logic [NUM_MST-1:0]    mst_ready_o,
    output logic                  slv_valid_o,
    output logic [31:0]           slv_addr_o,
    output logic [31:0]           slv_wdata_o,
    output logic [3:0]            slv_wstrb_o,
    input  logic [31:0]           slv_rdata_i,
    input  logic                  slv_ready_i,
    output logic [NUM_MST-1:0]    grant_o,
    output logic                  busy_o
`ifdef NMI_ARB_TIMEOUT_EN
    ,
    output logic                  timeout_o
`endif
);

    localparam int IW = $clog2(NUM_MST);

    if (NUM_MST < 2 || NUM_MST > 8 || TIMEOUT_CYC < 1) begin : g_bad_cfg
        $error("nmi_arb: NUM_MST must be 2..8 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_MST-1:0] r_grant;
    logic [NUM_MST-1:0] w_grant_nxt;
    logic [IW-1:0]      r_last;
    logic [IW-1:0]      w_last_nxt;

    logic [NUM_MST-1:0] w_pick;
    logic               w_found;
    logic [IW:0]        w_sum;
    logic [IW-1:0]      w_idx;
    logic [IW-1:0]      w_gidx;
    logic [31:0]        w_addr;
    logic [31:0]        w_wdata;
    logic [3:0]         w_wstrb;
    logic               w_done;
    logic               w_to;
    logic               w_end;

    // Search starts just after the last served master, so it becomes
    // the lowest-priority candidate for this round.
    always_comb begin
        w_pick  = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_MST; k++) begin
            w_sum = {1'b0, r_last} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(NUM_MST)) begin
                w_sum = w_sum - (IW+1)'(NUM_MST);
            end
            w_idx = w_sum[IW-1:0];
            if (!w_found && mst_valid_i[w_idx]) begin
                w_pick[w_idx] = 1'b1;
                w_found       = 1'b1;
            end
        end
    end

    // Grant is zero outside BUSY, so this mux also yields the
    // all-zero slave fields when idle.
    always_comb begin
        w_gidx  = '0;
        w_addr  = '0;
        w_wdata = '0;
        w_wstrb = '0;
        for (int i = 0; i < NUM_MST; i++) begin
            if (r_grant[i]) begin
                w_gidx  = IW'(i);
                w_addr  = mst_addr_i[32*i +: 32];
                w_wdata = mst_wdata_i[32*i +: 32];
                w_wstrb = mst_wstrb_i[4*i +: 4];
            end
        end
    end

    assign w_done = (r_state == BUSY) && slv_ready_i;
    assign w_end  = w_done || w_to;

`ifdef NMI_ARB_TIMEOUT_EN
    localparam int CL = $clog2(TIMEOUT_CYC + 1);
    localparam int CW = (CL > 8) ? CL : 8;

    logic [CW-1:0] r_cnt;
    logic          r_timeout;

    // A slave ready in the limit cycle takes precedence over the watchdog.
    assign w_to = (r_state == BUSY) && !slv_ready_i
                  && (r_cnt == CW'(TIMEOUT_CYC));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state != BUSY) begin
                r_cnt <= '0;
            end else if (!slv_ready_i) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_to) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    assign w_to = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_last_nxt  = r_last;
        unique case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (w_end) begin
                    w_last_nxt  = w_gidx;
                    w_grant_nxt = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_last  <= IW'(NUM_MST - 1);
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign slv_valid_o = (r_state == BUSY);
    assign busy_o      = (r_state == BUSY);
    assign grant_o     = r_grant;
    assign slv_addr_o  = w_addr;
    assign slv_wdata_o = w_wdata;
    assign slv_wstrb_o = w_wstrb;
    assign mst_ready_o = w_end ? r_grant : '0;
    assign mst_rdata_o = w_done ? slv_rdata_i
                       : (w_to ? 32'hDEAD_BEEF : 32'h0);

endmodule
